// File: rtl/whistle_seq.sv
// Referee whistle sequencer: turns single-cycle game events into timed blast
// patterns on the whistle start line, with latched events and fixed priority.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | nothing playing; loads the highest-priority pending event
// BLAST   | start high for one blast of the current pattern
// GAP     | silence between two blasts of the same pattern
// HOLDOFF | silence after a pattern before anything else may play
module whistle_seq #(
    parameter int TICK_CYCLES = 100_000,
    parameter int SHORT_MS    = 150,
    parameter int LONG_MS     = 500,
    parameter int GAP_MS      = 200,
    parameter int HOLDOFF_MS  = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ev_serve,
    input  logic       ev_point,
    input  logic       ev_game_over,
    input  logic       mute,
    output logic       start,
    output logic       busy,
    output logic [1:0] pattern_id
);

    localparam int SHORT_CYC = SHORT_MS * TICK_CYCLES;
    localparam int LONG_CYC  = LONG_MS * TICK_CYCLES;
    localparam int GAP_CYC   = GAP_MS * TICK_CYCLES;
    localparam int HOLD_CYC  = HOLDOFF_MS * TICK_CYCLES;

    // The duration counter must hold the largest reload value of any timed state.
    localparam int MAX_A   = (LONG_CYC > SHORT_CYC) ? LONG_CYC : SHORT_CYC;
    localparam int MAX_B   = (GAP_CYC > HOLD_CYC) ? GAP_CYC : HOLD_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    // Down-counter reload values: a state lasting N cycles loads N-1 and exits at 0.
    localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(SHORT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLAST = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Pattern id doubles as the blast count (serve 1, point 2, game over 3).
    // Only game over uses long blasts, on its first and last blast.
    function automatic logic [CNT_W-1:0] blast_ld(input logic [1:0] pat, input logic [1:0] idx);
        return (pat == 2'd3 && idx != 2'd1) ? LONG_LD : SHORT_LD;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       pat_q, pat_d;
    logic [2:0]       flags_q, flags_d;     // bit0 serve, bit1 point, bit2 game over
    logic             start_q, start_d;
    logic             busy_q, busy_d;

    logic [2:0]       ev_in;
    logic [2:0]       sel;
    logic [1:0]       sel_pat;

    // Next-state, timer, pending-flag and registered-output computation.
    always_comb begin
        ev_in   = {ev_game_over, ev_point, ev_serve} & {3{~mute}};
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        flags_d = flags_q | ev_in;
        sel     = 3'b000;
        sel_pat = 2'd0;

        if (flags_q[2]) begin
            sel     = 3'b100;
            sel_pat = 2'd3;
        end else if (flags_q[1]) begin
            sel     = 3'b010;
            sel_pat = 2'd2;
        end else if (flags_q[0]) begin
            sel     = 3'b001;
            sel_pat = 2'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (|flags_q) begin
                    // A repeat of the event being loaded merges into this play.
                    state_d = ST_BLAST;
                    pat_d   = sel_pat;
                    idx_d   = 2'd0;
                    cnt_d   = blast_ld(sel_pat, 2'd0);
                    flags_d = (flags_q | ev_in) & ~sel;
                end
            end
            ST_BLAST: begin
                if (cnt_q == '0) begin
                    if ((idx_q + 2'd1) < pat_q) begin
                        state_d = ST_GAP;
                        idx_d   = idx_q + 2'd1;
                        cnt_d   = GAP_LD;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_BLAST;
                    cnt_d   = blast_ld(pat_q, idx_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    pat_d   = 2'd0;
                    idx_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                pat_d   = 2'd0;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase

        start_d = (state_d == ST_BLAST);
        busy_d  = (state_d != ST_IDLE) || (|flags_d);
    end

    // State, counters, flags and outputs; synchronous reset drops everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            pat_q   <= 2'd0;
            flags_q <= 3'b000;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            flags_q <= flags_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    assign start      = start_q;
    assign busy       = busy_q;
    assign pattern_id = pat_q;

endmodule

// File: tb/tb_whistle_seq.sv
// Bench for whistle_seq: directed scenarios plus random events, all outputs
// compared every cycle against a per-cycle schedule model of the whistle.
module tb_whistle_seq;

    localparam int T = 4;
    localparam int S = 2;
    localparam int L = 5;
    localparam int G = 3;
    localparam int H = 4;
    localparam int NLOG = 128;

    logic       clk = 1'b0;
    logic       rst;
    logic       ev_serve, ev_point, ev_game_over, mute;
    logic       start, busy;
    logic [1:0] pattern_id;

    int checks = 0;
    int errors = 0;

    whistle_seq #(
        .TICK_CYCLES(T), .SHORT_MS(S), .LONG_MS(L), .GAP_MS(G), .HOLDOFF_MS(H)
    ) dut (
        .clk(clk), .rst(rst), .ev_serve(ev_serve), .ev_point(ev_point),
        .ev_game_over(ev_game_over), .mute(mute), .start(start), .busy(busy),
        .pattern_id(pattern_id)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: on a load, the whole pattern is expanded into a queue
    // holding the expected start level for every following cycle.
    bit m_q[$];
    int m_pid = 0;
    bit [2:0] m_flags = 3'b000;
    bit m_chk = 1'b0;

    function automatic void push_run(input bit lvl, input int n);
        for (int i = 0; i < n; i++) m_q.push_back(lvl);
    endfunction

    always @(posedge clk) begin : model
        bit [2:0] ev;
        int p;
        ev = {ev_game_over, ev_point, ev_serve} & {3{~mute}};
        if (rst) begin
            m_q.delete();
            m_pid = 0;
            m_flags = 3'b000;
        end else if (m_q.size() > 0) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_pid = 0;
            m_flags = m_flags | ev;
        end else if (m_flags != 3'b000) begin
            p = m_flags[2] ? 3 : (m_flags[1] ? 2 : 1);
            if (p == 1) push_run(1'b1, S * T);
            if (p == 2) begin
                push_run(1'b1, S * T); push_run(1'b0, G * T); push_run(1'b1, S * T);
            end
            if (p == 3) begin
                push_run(1'b1, L * T); push_run(1'b0, G * T); push_run(1'b1, S * T);
                push_run(1'b0, G * T); push_run(1'b1, L * T);
            end
            push_run(1'b0, H * T);
            m_pid = p;
            m_flags = (m_flags | ev) & ~(3'b001 << (p - 1));
        end else begin
            m_flags = m_flags | ev;
        end
    end

    always @(negedge clk) begin
        if (m_chk) begin
            check_val("model_start", 32'(start), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
            check_val("model_busy", 32'(busy), 32'((m_q.size() > 0) || (m_flags != 3'b000)));
            check_val("model_pid", 32'(pattern_id), 32'(m_pid));
        end
    end

    // Directed schedule: inputs per cycle, outputs logged per cycle.
    bit sch_s[NLOG], sch_p[NLOG], sch_g[NLOG], sch_m[NLOG], sch_r[NLOG];
    bit lg_start[NLOG], lg_busy[NLOG];
    int lg_pid[NLOG];

    task automatic clear_sched();
        for (int i = 0; i < NLOG; i++) begin
            sch_s[i] = 0; sch_p[i] = 0; sch_g[i] = 0; sch_m[i] = 0; sch_r[i] = 0;
        end
    endtask

    task automatic run_sched(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ev_serve = sch_s[i]; ev_point = sch_p[i]; ev_game_over = sch_g[i];
            mute = sch_m[i]; rst = sch_r[i];
            @(negedge clk);
            lg_start[i] = start; lg_busy[i] = busy; lg_pid[i] = int'(pattern_id);
        end
        @(posedge clk);
        #1;
        ev_serve = 0; ev_point = 0; ev_game_over = 0; mute = 0; rst = 0;
    endtask

    function automatic int first_rise(input int from, input int n);
        for (int i = (from < 1 ? 1 : from); i < n; i++)
            if (lg_start[i] && !lg_start[i-1]) return i;
        return -1;
    endfunction

    function automatic int rise_count(input int from, input int n);
        int c = 0;
        for (int i = (from < 1 ? 1 : from); i < n; i++)
            if (lg_start[i] && !lg_start[i-1]) c++;
        return c;
    endfunction

    function automatic int busy_drop(input int from, input int n);
        for (int i = from; i < n; i++)
            if (!lg_busy[i]) return i;
        return -1;
    endfunction

    function automatic int high_len(input int from, input int n);
        int c = 0;
        for (int i = from; i < n; i++) begin
            if (!lg_start[i]) return c;
            c++;
        end
        return c;
    endfunction

    initial begin
        int busy_cnt;
        rst = 1; ev_serve = 0; ev_point = 0; ev_game_over = 0; mute = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check_val("reset_start", 32'(start), 32'd0);
        check_val("reset_busy", 32'(busy), 32'd0);
        check_val("reset_pid", 32'(pattern_id), 32'd0);
        m_chk = 1;

        // point alone
        clear_sched(); sch_p[0] = 1; run_sched(60);
        check_val("pt_first_rise", first_rise(1, 60), 2);
        check_val("pt_blast1_len", high_len(2, 60), 8);
        check_val("pt_second_rise", first_rise(3, 60), 22);
        check_val("pt_blast2_len", high_len(22, 60), 8);
        check_val("pt_busy_drop", busy_drop(2, 60), 46);
        check_val("pt_busy_45", 32'(lg_busy[45]), 1);
        check_val("pt_pid_mid", lg_pid[15], 2);
        check_val("pt_pid_idle", lg_pid[46], 0);

        // game over alone
        clear_sched(); sch_g[0] = 1; run_sched(100);
        check_val("go_rises", rise_count(1, 100), 3);
        check_val("go_blast1_len", high_len(2, 100), 20);
        check_val("go_blast2_len", high_len(34, 100), 8);
        check_val("go_blast3_len", high_len(54, 100), 20);
        check_val("go_pid", lg_pid[40], 3);

        // serve and point together
        clear_sched(); sch_s[0] = 1; sch_p[0] = 1; run_sched(80);
        check_val("both_pid_first", lg_pid[2], 2);
        check_val("both_idle_pid", lg_pid[46], 0);
        check_val("both_idle_busy", 32'(lg_busy[46]), 1);
        check_val("both_serve_rise", first_rise(31, 80), 47);
        check_val("both_serve_len", high_len(47, 80), 8);
        check_val("both_serve_pid", lg_pid[50], 1);
        check_val("both_rises", rise_count(1, 80), 3);

        // repeated serve during point merges into one play
        clear_sched(); sch_p[0] = 1; sch_s[5] = 1; sch_s[15] = 1; sch_s[25] = 1; run_sched(80);
        check_val("merge_rises", rise_count(1, 80), 3);

        // muted event is dropped
        clear_sched(); sch_p[0] = 1;
        for (int i = 0; i < 10; i++) sch_m[i] = 1;
        run_sched(40);
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) if (lg_busy[i] || lg_start[i]) busy_cnt++;
        check_val("mute_quiet", busy_cnt, 0);

        // mute after latch does not cancel
        clear_sched(); sch_p[0] = 1;
        for (int i = 1; i < 60; i++) sch_m[i] = 1;
        run_sched(60);
        check_val("mute_late_rises", rise_count(1, 60), 2);

        // reset in second blast of game over
        clear_sched(); sch_g[0] = 1; sch_r[37] = 1; run_sched(120);
        check_val("rst_pre_start", 32'(lg_start[37]), 1);
        check_val("rst_start", 32'(lg_start[38]), 0);
        check_val("rst_busy", 32'(lg_busy[38]), 0);
        check_val("rst_pid", lg_pid[38], 0);
        check_val("rst_no_more", rise_count(38, 120), 0);

        // random events, mute and rare resets against the model
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            ev_serve     = ($urandom_range(0, 39) == 0);
            ev_point     = ($urandom_range(0, 49) == 0);
            ev_game_over = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 99) == 0) mute = ~mute;
            rst          = ($urandom_range(0, 1499) == 0);
        end
        @(posedge clk);
        #1;
        ev_serve = 0; ev_point = 0; ev_game_over = 0; mute = 0; rst = 0;
        repeat (200) @(posedge clk);
        @(negedge clk);
        check_val("final_quiet", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
